parity_checker: RTL
===================

Name: parity_checker

Overview:
- Receive-side counterpart of the 8-bit parity generator. Deserialises 9-bit frames (8 data bits + 1 parity bit), checks them against even or odd parity, and presents the data byte with a one-cycle valid strobe and an error flag.
- Sits after the generator in the lab datapath: the generator's Even/Odd 9-bit word is shifted in serially, LSB first.

Parameters:
- DATA_W, 8, data bits per frame; frame length is DATA_W+1.
- CNT_W, 8, width of the saturating parity-error counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- Mode  input  1  0 = even parity check, 1 = odd parity check; sampled only when Start is accepted.
- Start  input  1  frame-start strobe, one cycle.
- SerIn  input  1  serial frame bit.
- SerValid  input  1  SerIn is valid this cycle.
- Data  output  DATA_W  received data byte; held until the next frame completes.
- DataValid  output  1  one-cycle pulse when a frame completes.
- ParityErr  output  1  parity result of the last frame; valid with DataValid, held afterwards.
- Busy  output  1  high while in SHIFT.
- ClrCnt  input  1  synchronous clear of ErrCount (present only with the macro).
- ErrCount  output  CNT_W  saturating error count (present only with the macro).

Behaviour:
- Reset (asynchronous, rst_n=0): state IDLE, Data=0, DataValid=0, ParityErr=0, Busy=0, bit counter=0, shift register=0, ErrCount=0.
- Frame format: bit index 0..DATA_W-1 are data, LSB first. Bit DATA_W is the parity bit, matching generator output bit 8.
- FSM states: IDLE, SHIFT, DONE.
- IDLE → SHIFT on Start=1:
  - Latch Mode, clear the bit counter and running XOR.
  - SerIn is not sampled in the Start cycle.
- In SHIFT:
  - Each cycle with SerValid=1: shift SerIn in, XOR it into the running parity, increment the counter.
  - SerValid=0: hold all state; gaps of any length are allowed.
- SHIFT → DONE on the clock edge that captures bit DATA_W (the counter reaching DATA_W+1).
- DONE (exactly one cycle):
  - DataValid=1; Data = captured data bits.
  - ParityErr = XOR of all 9 bits XOR latched Mode. A legal even frame XORs to 0; a legal odd frame XORs to 1.
  - Next state is IDLE, or SHIFT if Start=1 in this cycle (back-to-back frames).
- Latency: DataValid rises one cycle after the edge capturing the last bit.
- Start while in SHIFT: abort the current frame with no DataValid; restart with the counter at 0 and Mode re-latched.
- Start and SerValid in the same cycle: Start wins; that SerIn is discarded.
- SerValid while in IDLE: ignored.
- Mode changes mid-frame have no effect.
- Reset asserted mid-frame: immediate return to IDLE; the partial frame is discarded.
- Data and ParityErr change only in DONE.

Optional Feature:
- Macro PARITY_CHECK_ERRCNT_EN.
- Defined:
  - ClrCnt and ErrCount ports exist.
  - ErrCount increments in every DONE cycle where ParityErr=1, saturating at 2^CNT_W-1.
  - ClrCnt=1 clears it to 0; if ClrCnt and an error coincide, the clear wins and the result is 0.
- Undefined: both ports and the counter are absent; all other behaviour is identical.

Decomposition:
- Shared package parity_pkg holds:
  - FRAME_W = DATA_W+1.
  - Mode encodings PAR_EVEN=1'b0 and PAR_ODD=1'b1, shared with the generator.
  - FSM state encoding IDLE/SHIFT/DONE.
- One natural sub-module, sat_counter, for the saturating error counter; it is instantiated only under the macro.

Test Plan:
- Even mode, frame 9'h0A5 (data A5, parity 0), contiguous SerValid → DataValid one cycle after the 9th bit, Data=8'hA5, ParityErr=0.
- Odd mode, same frame 9'h0A5 → Data=8'hA5, ParityErr=1. Then odd mode, frame 9'h1A5 → ParityErr=0.
- Even mode, frame 9'h107 with SerValid low for 3 cycles between bits 4 and 5 → Data=8'h07, ParityErr=0, Busy high throughout.
- Start reasserted after 4 bits, then full frame 9'h000 in even mode → exactly one DataValid, Data=8'h00, ParityErr=0.
- rst_n pulled low after 6 bits → all outputs 0 immediately. Then frame 9'h1FF in odd mode → Data=8'hFF, ParityErr=0.
- With PARITY_CHECK_ERRCNT_EN and CNT_W=2:
  - 5 bad frames → ErrCount sequence 1,2,3,3,3.
  - ClrCnt coinciding with a 6th error → ErrCount=0.

Source files
------------

// File: rtl/parity_pkg.sv
// Shared definitions for the parity generator/checker pair: frame geometry, mode codes, FSM states.
package parity_pkg;

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned FRAME_W    = DEF_DATA_W + 1;

  // Mode encodings shared with the generator.
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } state_e;

  function automatic int unsigned frame_len(input int unsigned data_w);
    return data_w + 1;
  endfunction

endpackage

// File: rtl/parity_checker_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module sat_counter #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [Width-1:0] count_o
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != {Width{1'b1}})) begin
      count_d = count_q + Width'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/parity_checker.sv
// Serial parity checker: deserialises DATA_W+1 bit frames LSB first and flags parity errors.
// Optional saturating error counter enabled by PARITY_CHECK_ERRCNT_EN.
module parity_checker
  import parity_pkg::*;
#(
  parameter int unsigned DATA_W = 8
`ifdef PARITY_CHECK_ERRCNT_EN
  ,
  parameter int unsigned CNT_W  = 8
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              Mode,
  input  logic              Start,
  input  logic              SerIn,
  input  logic              SerValid,
  output logic [DATA_W-1:0] Data,
  output logic              DataValid,
  output logic              ParityErr,
`ifdef PARITY_CHECK_ERRCNT_EN
  input  logic              ClrCnt,
  output logic [CNT_W-1:0]  ErrCount,
`endif
  output logic              Busy
);

  localparam int unsigned FrameW = frame_len(DATA_W);
  localparam int unsigned CntW   = $clog2(FrameW + 1);
  localparam logic [CntW-1:0] LastIdx = CntW'(DATA_W);

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              par_q, par_d;
  logic              mode_q, mode_d;
  logic              perr_q, perr_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shift_d = shift_q;
    data_d  = data_q;
    par_d   = par_q;
    mode_d  = mode_q;
    perr_d  = perr_q;

    // Start from any state (re)opens a frame; the SerIn of the Start cycle is dropped.
    if (Start) begin
      state_d = StShift;
      cnt_d   = '0;
      shift_d = '0;
      par_d   = 1'b0;
      mode_d  = Mode;
    end else begin
      case (state_q)
        StShift: begin
          if (SerValid) begin
            par_d = par_q ^ SerIn;
            cnt_d = cnt_q + CntW'(1);
            if (cnt_q == LastIdx) begin
              state_d = StDone;
              data_d  = shift_q;
              perr_d  = par_q ^ SerIn ^ mode_q;
            end else begin
              shift_d = {SerIn, shift_q[DATA_W-1:1]};
            end
          end
        end
        StDone:  state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      par_q   <= 1'b0;
      mode_q  <= PAR_EVEN;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      par_q   <= par_d;
      mode_q  <= mode_d;
      perr_q  <= perr_d;
    end
  end

  assign Data      = data_q;
  assign ParityErr = perr_q;
  assign DataValid = (state_q == StDone);
  assign Busy      = (state_q == StShift);

`ifdef PARITY_CHECK_ERRCNT_EN
  sat_counter #(
    .Width (CNT_W)
  ) u_err_cnt (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (ClrCnt),
    .inc_i   (DataValid && perr_q),
    .count_o (ErrCount)
  );
`endif

endmodule
